// File: rtl/output_stream_writer.sv
// Collects per-pixel conv results for one image into a small register FIFO and
// streams them out as sign-extended AXI4-Stream beats, with row and image completion pulses.
module output_stream_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int AXIS_WIDTH = 256,
  parameter int FIFO_DEPTH = 8,
  parameter int SIZE_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Start_image,
  input  logic [SIZE_WIDTH-1:0] IMAGE_SIZE,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  Done_1row,
  output logic                  Done_image,
  output logic                  Busy
);

  // state  | meaning
  // IDLE   | waiting for Start_image with a nonzero size
  // STREAM | accepting din and emitting beats independently
  // DONE   | one-cycle Done_image pulse after the TLAST handshake

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = 2 * SIZE_WIDTH;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        fifo_cnt;
  logic [SIZE_WIDTH-1:0] size_q, col_cnt, row_cnt;
  logic [CNT_W-1:0]      total, in_cnt, out_cnt;
  logic                  done_row_q;
  logic                  fifo_full, fifo_empty, push, pop;
  logic [DATA_WIDTH-1:0] head;

  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign head       = mem[rd_ptr];

  // Ready ignores tready on purpose: a full FIFO never accepts, even on a pop cycle.
  assign din_ready     = (state == STREAM) && !fifo_full && (in_cnt < total);
  assign m_axis_tvalid = (state == STREAM) && !fifo_empty;
  assign m_axis_tlast  = m_axis_tvalid && (out_cnt == total - CNT_W'(1));
  assign m_axis_tdata  = AXIS_WIDTH'($signed(head));

  assign push = din_valid && din_ready;
  assign pop  = m_axis_tvalid && m_axis_tready;

  assign Done_1row  = done_row_q;
  assign Done_image = (state == DONE);
  assign Busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      size_q     <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      total      <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      done_row_q <= 1'b0;
    end else begin
      done_row_q <= 1'b0;

      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
        in_cnt      <= in_cnt + CNT_W'(1);
      end

      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        out_cnt <= out_cnt + CNT_W'(1);
        if (col_cnt == size_q - SIZE_WIDTH'(1)) begin
          col_cnt    <= '0;
          row_cnt    <= row_cnt + SIZE_WIDTH'(1);
          done_row_q <= 1'b1;
        end else begin
          col_cnt <= col_cnt + SIZE_WIDTH'(1);
        end
      end

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      case (state)
        IDLE: begin
          if (Start_image && (IMAGE_SIZE != '0)) begin
            size_q  <= IMAGE_SIZE;
            total   <= CNT_W'(IMAGE_SIZE) * CNT_W'(IMAGE_SIZE);
            in_cnt  <= '0;
            out_cnt <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (pop && (out_cnt == total - CNT_W'(1))) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
